// File: rtl/digit_entry.sv
// Key/switch front end for the combination lock: synchronises and debounces the
// push button, then emits one clean digit strobe per press with sequence tracking.
module digit_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter int DIGIT_W         = 4,
  parameter int SEQ_LEN         = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               key_n,
  input  logic [DIGIT_W-1:0] sw,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  output logic [1:0]         digit_index,
  output logic               seq_done,
  output logic               abort,
  output logic               busy,
  output logic               key_level
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST  = TM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      IDX_LAST = 2'(SEQ_LEN - 1);

  typedef enum logic {IDLE, ENTRY} state_t;

  logic               key_n_p0, key_n_p1;
  logic [DIGIT_W-1:0] sw_p0, sw_p1;
  logic [DB_W-1:0]    db_cnt;
  logic               key_pressed;
  logic               press;

  state_t             state, state_nx;
  logic [1:0]         cnt, cnt_nx;
  logic [TM_W-1:0]    timer, timer_nx;
  logic [DIGIT_W-1:0] digit_nx;
  logic [1:0]         index_nx;
  logic               vld_nx, seq_done_nx, abort_nx, busy_nx;

  // Stage p0/p1: two-flop synchroniser, idle values are key released, switches 0
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_n_p0 <= 1'b1;
      key_n_p1 <= 1'b1;
      sw_p0    <= '0;
      sw_p1    <= '0;
    end else begin
      key_n_p0 <= key_n;
      key_n_p1 <= key_n_p0;
      sw_p0    <= sw;
      sw_p1    <= sw_p0;
    end
  end

  assign key_pressed = ~key_n_p1;
  // A press is the debounced level about to go 0->1 on this edge
  assign press = key_pressed & ~key_level & (db_cnt == DB_LAST);

  // Debounce stage: level follows the synced key after DEBOUNCE_CYCLES differing cycles
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_level <= 1'b0;
      db_cnt    <= '0;
    end else if (key_pressed != key_level) begin
      if (db_cnt == DB_LAST) begin
        key_level <= ~key_level;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Sequence stage: registered strobes and progress tracking
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      digit       <= '0;
      digit_index <= '0;
      digit_valid <= 1'b0;
      seq_done    <= 1'b0;
      abort       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      timer       <= timer_nx;
      digit       <= digit_nx;
      digit_index <= index_nx;
      digit_valid <= vld_nx;
      seq_done    <= seq_done_nx;
      abort       <= abort_nx;
      busy        <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    timer_nx    = timer;
    digit_nx    = digit;
    index_nx    = digit_index;
    vld_nx      = 1'b0;
    seq_done_nx = 1'b0;
    abort_nx    = 1'b0;
    if (press) begin
      digit_nx = sw_p1;
      vld_nx   = 1'b1;
    end
    case (state)
      IDLE: begin
        if (press) begin
          index_nx = 2'd0;
          if (SEQ_LEN == 1) begin
            seq_done_nx = 1'b1;
          end else begin
            cnt_nx   = 2'd1;
            timer_nx = '0;
            state_nx = ENTRY;
          end
        end
      end
      ENTRY: begin
        // A press on the timeout cycle wins and restarts the timer
        if (press) begin
          index_nx = cnt;
          timer_nx = '0;
          if (cnt == IDX_LAST) begin
            seq_done_nx = 1'b1;
            cnt_nx      = 2'd0;
            state_nx    = IDLE;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end else if (timer == TM_LAST) begin
          abort_nx = 1'b1;
          cnt_nx   = 2'd0;
          timer_nx = '0;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + TM_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == ENTRY);
  end

endmodule

// File: tb/tb_digit_entry.sv
// Randomised bench for digit_entry against an event-level model of press
// detection, sequence position and inactivity timeout.
module tb_digit_entry;

  localparam int D   = 4;
  localparam int T   = 20;
  localparam int SEQ = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       key_n;
  logic [3:0] sw;
  logic [3:0] digit;
  logic       digit_valid;
  logic [1:0] digit_index;
  logic       seq_done, abort, busy, key_level;

  int n_checks = 0;
  int n_errors = 0;

  digit_entry #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T),
    .DIGIT_W        (4),
    .SEQ_LEN        (SEQ)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .key_n      (key_n),
    .sw         (sw),
    .digit      (digit),
    .digit_valid(digit_valid),
    .digit_index(digit_index),
    .seq_done   (seq_done),
    .abort      (abort),
    .busy       (busy),
    .key_level  (key_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: inputs reach the logic two edges late; the level flips after
  // D consecutive disagreeing samples; digits are counted per sequence.
  logic       key_q[$];
  logic [3:0] sw_q[$];
  logic       m_level;
  int         m_run, m_pos, m_since;
  logic [3:0] e_digit;
  logic [1:0] e_idx;
  logic       e_vld, e_done, e_abort;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input logic k, input logic [3:0] s, input logic r);
    logic       synced_key;
    logic [3:0] synced_sw;
    logic       pr;
    if (r) begin
      key_q = '{1'b1, 1'b1};
      sw_q  = '{4'd0, 4'd0};
      m_level = 1'b0; m_run = 0; m_pos = 0; m_since = 0;
      e_digit = 4'd0; e_idx = 2'd0; e_vld = 1'b0; e_done = 1'b0; e_abort = 1'b0;
    end else begin
      synced_key = key_q.pop_front();
      synced_sw  = sw_q.pop_front();
      key_q.push_back(k);
      sw_q.push_back(s);
      pr = 1'b0;
      if ((!synced_key) != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = !m_level;
          m_run = 0;
          pr = m_level;
        end
      end else begin
        m_run = 0;
      end
      e_vld = pr; e_done = 1'b0; e_abort = 1'b0;
      if (pr) begin
        e_digit = synced_sw;
        e_idx   = 2'(m_pos);
        m_pos++;
        m_since = 0;
        if (m_pos == SEQ) begin
          e_done = 1'b1;
          m_pos = 0;
        end
      end else if (m_pos > 0) begin
        m_since++;
        if (m_since == T) begin
          e_abort = 1'b1;
          m_pos = 0;
        end
      end
    end
  endtask

  task automatic step(input logic k, input logic [3:0] s, input logic r);
    key_n = k; sw = s; reset = r;
    @(posedge CLOCK_50);
    model_edge(k, s, r);
    #1;
    chk("digit_valid", 32'(digit_valid), 32'(e_vld));
    chk("digit", 32'(digit), 32'(e_digit));
    chk("digit_index", 32'(digit_index), 32'(e_idx));
    chk("seq_done", 32'(seq_done), 32'(e_done));
    chk("abort", 32'(abort), 32'(e_abort));
    chk("busy", 32'(busy), 32'(m_pos > 0));
    chk("key_level", 32'(key_level), 32'(m_level));
  endtask

  // Hold key low for 'hold' cycles; switches change to s_after once the digit is safely captured
  task automatic press(input logic [3:0] s, input int hold, input logic [3:0] s_after);
    for (int i = 0; i < hold; i++) step(1'b0, (i < D + 2) ? s : s_after, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, sw, 1'b0);
  endtask

  task automatic tap(input logic [3:0] s);
    press(s, D + 6, s);
    idle(D + 4);
  endtask

  initial begin
    int guard;
    key_n = 1'b1; sw = 4'd0; reset = 1'b1;
    step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'hF, 1'b1);
    // Clean press and release
    press(4'b1000, 10, 4'b1000);
    idle(10);
    // Bouncy press
    step(1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 0, 4'b0101, 1'b0);
    press(4'b0101, 10, 4'b0101);
    idle(10);
    // Full sequence, switches moved while key held
    step(1'b1, 4'd0, 1'b1);
    tap(4'b1000);
    press(4'b0100, D + 6, 4'b1111);
    idle(D + 4);
    tap(4'b0010);
    tap(4'b0001);
    // Timeout after two digits, then a fresh press
    tap(4'h3);
    tap(4'h6);
    idle(2 * T);
    tap(4'h9);
    idle(2 * T);
    // Third press lands on the timeout cycle
    tap(4'h1);
    press(4'h2, D + 3, 4'h2);
    guard = 0;
    while (m_since != T - D - 2 && guard < 100) begin
      step(1'b1, 4'h4, 1'b0);
      guard++;
    end
    chk("race_setup", 32'(m_since), 32'(T - D - 2));
    press(4'h4, D + 4, 4'h4);
    idle(2 * T);
    // Reset mid-entry, then key held through reset release
    tap(4'h7);
    tap(4'h8);
    step(1'b1, 4'h8, 1'b1);
    tap(4'hA);
    step(1'b0, 4'hB, 1'b1);
    press(4'hB, D + 6, 4'hC);
    idle(2 * T);
    // Randomised presses, bounce, gaps and occasional resets
    for (int n = 0; n < 60; n++) begin
      logic [3:0] s;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) step(1'($urandom_range(0, 1)), s, 1'b1);
      for (int b = 0; b < int'($urandom_range(0, 6)); b++) step(1'($urandom_range(0, 1)), s, 1'b0);
      press(s, int'($urandom_range(D + 3, D + 12)), 4'($urandom_range(0, 15)));
      for (int b = 0; b < int'($urandom_range(0, 4)); b++) step(1'($urandom_range(0, 1)), sw, 1'b0);
      idle(int'($urandom_range(D + 3, 2 * T + 5)));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
